// File: rtl/gemm_c_tile_drain_pkg.sv
// Shared geometry and types for the C-tile drain path behind the 4x16 MAC array.
package gemm_c_tile_drain_pkg;

   localparam int unsigned OutDataWidth = 32;
   localparam int unsigned RowPar       = 4;
   localparam int unsigned ColPar       = 16;
   localparam int unsigned WordElems    = 4;

   localparam int unsigned TileWidth    = RowPar * ColPar * OutDataWidth;
   localparam int unsigned WordWidth    = WordElems * OutDataWidth;
   localparam int unsigned WordsPerRow  = ColPar / WordElems;
   localparam int unsigned BeatsPerTile = RowPar * WordsPerRow;
   localparam int unsigned BeatWidth    = $clog2(BeatsPerTile);
   localparam int unsigned WordSelWidth = $clog2(WordsPerRow);

   typedef logic [TileWidth-1:0] tile_t;
   typedef logic [WordWidth-1:0] c_word_t;
   typedef logic [BeatWidth-1:0] beat_t;

endpackage

// File: rtl/gemm_c_tile_drain_if.sv
// Tile handshake between the MAC array (master) and the drain (slave).
interface gemm_c_tile_drain_if;
   import gemm_c_tile_drain_pkg::*;

   logic  tile_valid_i;
   logic  tile_ready_o;
   tile_t tile_data_i;

   modport master (output tile_valid_i, output tile_data_i, input tile_ready_o);
   modport slave  (input tile_valid_i, input tile_data_i, output tile_ready_o);

endinterface

// File: rtl/gemm_c_tile_drain_buffer.sv
// Two-slot ping-pong tile store; the caller guarantees no push when full and no pop when empty.
module tile_pingpong_buffer
   import gemm_c_tile_drain_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push,
   input  logic       pop,
   input  tile_t      wr_data,
   output tile_t      rd_data,
   output logic [1:0] count
);

   tile_t      slot_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;

   // Occupancy: a push and a pop in the same cycle leave the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Pointers and count; reset empties the store.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_d;
      end
   end

   // Slot payload needs no reset: it is only read while the count says it is valid.
   always_ff @(posedge clk_i) begin
      if (push) slot_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = slot_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/gemm_c_tile_drain.sv
// Drains finished 4x16 int32 tiles into 128-bit C-SRAM words in row-major order.
module gemm_c_tile_drain
   import gemm_c_tile_drain_pkg::*;
#(
   parameter int unsigned AddrWidth     = 12,
   parameter int unsigned SizeAddrWidth = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [SizeAddrWidth-1:0] M_size_i,
   input  logic [SizeAddrWidth-1:0] N_size_i,
   gemm_c_tile_drain_if.slave       tile,
   output logic [AddrWidth-1:0]     sram_c_addr_o,
   output c_word_t                  sram_c_wdata_o,
   output logic                     sram_c_we_o,
   output logic                     done_o,
   output logic                     err_o
);

   typedef logic [SizeAddrWidth-1:0] size_t;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0] state_q, state_d;
   size_t      m_tiles_q, m_tiles_d;
   size_t      n_tiles_q, n_tiles_d;
   size_t      n_words_q, n_words_d;
   size_t      tile_m_q, tile_m_d;
   size_t      tile_n_q, tile_n_d;
   beat_t      beat_q, beat_d;
   logic       err_q, err_d;

   logic [AddrWidth-1:0] addr_q;
   c_word_t              wdata_q;
   logic                 we_q;
   logic                 done_q;

   logic [1:0] count;
   tile_t      rd_tile;
   logic       accept, issue, pop, last_tile, size_ok;
   size_t      row, addr_full;
   logic [BeatWidth-WordSelWidth-1:0] beat_row;
   logic [WordSelWidth-1:0]           beat_word;

   assign size_ok = (M_size_i != '0) && (N_size_i != '0) &&
                    ((M_size_i % size_t'(RowPar)) == '0) &&
                    ((N_size_i % size_t'(ColPar)) == '0);

   assign tile.tile_ready_o = (state_q == StRun) && (count != 2'd2);
   assign accept    = tile.tile_valid_i && tile.tile_ready_o;
   assign issue     = (state_q == StRun) && (count != 2'd0);
   assign pop       = issue && (beat_q == beat_t'(BeatsPerTile - 1));
   assign last_tile = (tile_m_q == m_tiles_q - size_t'(1)) &&
                      (tile_n_q == n_tiles_q - size_t'(1));

   // Beat index splits into tile row (outer) and word within the row (inner).
   assign beat_row  = beat_q[BeatWidth-1:WordSelWidth];
   assign beat_word = beat_q[WordSelWidth-1:0];
   assign row       = tile_m_q * size_t'(RowPar) + size_t'(beat_row);
   assign addr_full = row * n_words_q + tile_n_q * size_t'(WordsPerRow) + size_t'(beat_word);

   tile_pingpong_buffer u_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push    (accept),
      .pop     (pop),
      .wr_data (tile.tile_data_i),
      .rd_data (rd_tile),
      .count   (count)
   );

   // Job FSM, size latch and tile/beat walk.
   always_comb begin
      state_d   = state_q;
      m_tiles_d = m_tiles_q;
      n_tiles_d = n_tiles_q;
      n_words_d = n_words_q;
      tile_m_d  = tile_m_q;
      tile_n_d  = tile_n_q;
      beat_d    = beat_q;
      err_d     = err_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               err_d    = !size_ok;
               tile_m_d = '0;
               tile_n_d = '0;
               beat_d   = '0;
               if (size_ok) begin
                  m_tiles_d = M_size_i / size_t'(RowPar);
                  n_tiles_d = N_size_i / size_t'(ColPar);
                  n_words_d = N_size_i / size_t'(WordElems);
                  state_d   = StRun;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            if (issue) begin
               beat_d = beat_q + beat_t'(1);
               if (pop) begin
                  beat_d = '0;
                  if (tile_n_q == n_tiles_q - size_t'(1)) begin
                     tile_n_d = '0;
                     tile_m_d = tile_m_q + size_t'(1);
                  end else begin
                     tile_n_d = tile_n_q + size_t'(1);
                  end
                  if (last_tile) state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         m_tiles_q <= '0;
         n_tiles_q <= '0;
         n_words_q <= '0;
         tile_m_q  <= '0;
         tile_n_q  <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_tiles_q <= m_tiles_d;
         n_tiles_q <= n_tiles_d;
         n_words_q <= n_words_d;
         tile_m_q  <= tile_m_d;
         tile_n_q  <= tile_n_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
      end
   end

   // Registered SRAM port; done trails the DONE state by one cycle so it follows the last write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         we_q   <= issue;
         done_q <= (state_q == StDone);
         if (issue) begin
            addr_q  <= AddrWidth'(addr_full);
            // Words of a row-major tile are contiguous, so beat k is simply word k.
            wdata_q <= rd_tile[int'(beat_q) * WordWidth +: WordWidth];
         end
      end
   end

   assign sram_c_addr_o  = addr_q;
   assign sram_c_wdata_o = wdata_q;
   assign sram_c_we_o    = we_q;
   assign done_o         = done_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_gemm_c_tile_drain.sv
// Directed bench for gemm_c_tile_drain: single tile, streaming, backpressure, size error,
// mid-job reset and start-during-run.
module tb_gemm_c_tile_drain;
   import gemm_c_tile_drain_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] m_size = '0;
   logic [31:0] n_size = '0;
   logic [11:0] addr;
   c_word_t     wdata;
   logic        we, done, err;

   gemm_c_tile_drain_if tif ();

   gemm_c_tile_drain #(.AddrWidth(12), .SizeAddrWidth(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .M_size_i       (m_size),
      .N_size_i       (n_size),
      .tile           (tif),
      .sram_c_addr_o  (addr),
      .sram_c_wdata_o (wdata),
      .sram_c_we_o    (we),
      .done_o         (done),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int      n_checks = 0;
   int      n_fail = 0;
   c_word_t c_mem [0:4095];
   bit      c_written [0:4095];
   int      wr_cnt, gap_cnt, first_we_cyc, last_we_cyc, done_cnt, done_cyc, stall_cnt;
   int      acc_cyc [0:31];
   bit      abort_send;

   // SRAM and done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (we) begin
         if (wr_cnt > 0 && cyc != last_we_cyc + 1) gap_cnt++;
         if (wr_cnt == 0) first_we_cyc = cyc;
         last_we_cyc     = cyc;
         c_mem[addr]     = wdata;
         c_written[addr] = 1'b1;
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (tif.tile_valid_i && !tif.tile_ready_o) stall_cnt++;
   end

   function automatic tile_t make_tile(input int seed);
      tile_t t;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 16; c++) t[(r*16+c)*32 +: 32] = 32'(seed + r*16 + c);
      return t;
   endfunction

   // Golden C word: tile k of the job carries base + k*256 + r*16 + c.
   function automatic c_word_t expected_word(input int n, input int base, input int a);
      c_word_t wv;
      int      wpr, row, j, t;
      wpr = n / 4;
      row = a / wpr;
      for (int k = 0; k < 4; k++) begin
         j = (a % wpr) * 4 + k;
         t = (row / 4) * (n / 16) + j / 16;
         wv[k*32 +: 32] = 32'(base + t*256 + (row % 4)*16 + (j % 16));
      end
      return wv;
   endfunction

   task automatic clear_mon();
      for (int i = 0; i < 4096; i++) begin
         c_mem[i]     = '0;
         c_written[i] = 1'b0;
      end
      wr_cnt = 0; gap_cnt = 0; first_we_cyc = -1; last_we_cyc = -1;
      done_cnt = 0; done_cyc = -1; stall_cnt = 0; abort_send = 1'b0;
   endtask

   task automatic pulse_start(input int m, input int n, output int s_cyc);
      @(posedge clk); #1;
      start = 1'b1; m_size = 32'(m); n_size = 32'(n); s_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_tiles(input int n, input int base);
      bit ok;
      int budget;
      for (int k = 0; k < n; k++) begin
         if (abort_send) break;
         tif.tile_data_i  = make_tile(base + k*256);
         tif.tile_valid_i = 1'b1;
         ok = 1'b0; budget = 0;
         while (!ok && !abort_send && budget < 200) begin
            @(negedge clk);
            budget++;
            if (tif.tile_ready_o && !abort_send) begin
               acc_cyc[k] = cyc;
               @(posedge clk); #1;
               ok = 1'b1;
            end
         end
         if (!ok && !abort_send) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: tile %0d not accepted within %0d cycles", k, budget);
            break;
         end
      end
      tif.tile_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      int b = 0;
      int base_cnt = done_cnt;
      while (done_cnt == base_cnt && b < budget) begin
         @(negedge clk); #1;
         b++;
      end
      seen = (done_cnt != base_cnt);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (we !== 1'b0)    begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
      n_checks++; if (addr !== '0)    begin n_fail++; $display("FAIL reset_addr: got %0h want 0", addr); end
      n_checks++; if (wdata !== '0)   begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", wdata); end
      n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (tif.tile_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", tif.tile_ready_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_tile();
      int s, bad;
      bit seen;
      c_word_t want;
      clear_mon();
      pulse_start(4, 16, s);
      fork
         send_tiles(1, 0);
         wait_done(200, seen);
      join
      repeat (3) @(negedge clk);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_done_seen: got %b want 1", seen); end
      n_checks++; if (wr_cnt != 16) begin n_fail++; $display("FAIL single_wr_cnt: got %0d want 16", wr_cnt); end
      bad = 0;
      for (int a = 0; a < 16; a++)
         if (c_written[a] !== 1'b1 || c_mem[a] !== expected_word(16, 0, a)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_data: got %0d bad words want 0", bad); end
      want = {32'd7, 32'd6, 32'd5, 32'd4};
      n_checks++; if (c_mem[1] !== want) begin
         n_fail++; $display("FAIL single_word1: got %0h want %0h", c_mem[1], want);
      end
      // The first write appears on the edge after the accepting edge.
      n_checks++; if (first_we_cyc != acc_cyc[0] + 2) begin
         n_fail++; $display("FAIL single_first_we: got cyc %0d want %0d", first_we_cyc, acc_cyc[0] + 2);
      end
      n_checks++; if (done_cyc != last_we_cyc + 1) begin
         n_fail++; $display("FAIL single_done_lat: got cyc %0d want %0d", done_cyc, last_we_cyc + 1);
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_stream();
      int s, bad;
      bit seen;
      logic [31:0] v;
      c_word_t want;
      clear_mon();
      pulse_start(16, 64, s);
      fork
         send_tiles(16, 32'h10000);
         wait_done(1000, seen);
      join
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stream_done_seen: got %b want 1", seen); end
      n_checks++; if (wr_cnt != 256) begin n_fail++; $display("FAIL stream_wr_cnt: got %0d want 256", wr_cnt); end
      n_checks++; if (gap_cnt != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d want 0", gap_cnt); end
      n_checks++; if (last_we_cyc - first_we_cyc != 255) begin
         n_fail++; $display("FAIL stream_span: got %0d want 255", last_we_cyc - first_we_cyc);
      end
      v = 32'h10000 + 32'd6 * 32'd256;
      want = {v + 32'd3, v + 32'd2, v + 32'd1, v};
      n_checks++; if (c_mem[72] !== want) begin
         n_fail++; $display("FAIL stream_addr72: got %0h want %0h", c_mem[72], want);
      end
      bad = 0;
      for (int a = 0; a < 256; a++)
         if (c_written[a] !== 1'b1 || c_mem[a] !== expected_word(64, 32'h10000, a)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stream_data: got %0d bad words want 0", bad); end
      n_checks++; if (done_cyc != last_we_cyc + 1) begin
         n_fail++; $display("FAIL stream_done_lat: got cyc %0d want %0d", done_cyc, last_we_cyc + 1);
      end
   endtask

   task automatic test_backpressure();
      int s, bad;
      bit seen;
      clear_mon();
      pulse_start(12, 16, s);
      fork
         send_tiles(3, 32'h20000);
         wait_done(400, seen);
      join
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_done_seen: got %b want 1", seen); end
      n_checks++; if (acc_cyc[1] != acc_cyc[0] + 1) begin
         n_fail++; $display("FAIL bp_second_accept: got cyc %0d want %0d", acc_cyc[1], acc_cyc[0] + 1);
      end
      // Slot 0 frees on the edge its 16th beat is selected; the third tile lands the cycle after.
      n_checks++; if (acc_cyc[2] != acc_cyc[0] + 17) begin
         n_fail++; $display("FAIL bp_third_accept: got cyc %0d want %0d", acc_cyc[2], acc_cyc[0] + 17);
      end
      n_checks++; if (stall_cnt != 15) begin
         n_fail++; $display("FAIL bp_ready_low: got %0d cycles want 15", stall_cnt);
      end
      n_checks++; if (gap_cnt != 0 || wr_cnt != 48) begin
         n_fail++; $display("FAIL bp_writes: got %0d writes %0d gaps want 48 and 0", wr_cnt, gap_cnt);
      end
      bad = 0;
      for (int a = 0; a < 48; a++)
         if (c_written[a] !== 1'b1 || c_mem[a] !== expected_word(16, 32'h20000, a)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_data: got %0d bad words want 0", bad); end
   endtask

   task automatic test_size_error();
      int s;
      bit seen;
      clear_mon();
      pulse_start(6, 16, s);
      repeat (4) @(negedge clk);
      n_checks++; if (done_cnt != 1 || done_cyc != s + 2) begin
         n_fail++; $display("FAIL err_done: got %0d pulses at cyc %0d want 1 at %0d", done_cnt, done_cyc, s + 2);
      end
      n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL err_no_write: got %0d want 0", wr_cnt); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
      clear_mon();
      pulse_start(4, 8, s);
      repeat (4) @(negedge clk);
      n_checks++; if (err !== 1'b1 || done_cnt != 1 || wr_cnt != 0) begin
         n_fail++; $display("FAIL err_n8: got err %b done %0d writes %0d want 1 1 0", err, done_cnt, wr_cnt);
      end
      clear_mon();
      pulse_start(4, 16, s);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
      fork
         send_tiles(1, 32'h60000);
         wait_done(200, seen);
      join
      n_checks++; if (seen !== 1'b1 || wr_cnt != 16) begin
         n_fail++; $display("FAIL err_recover: got done %b writes %0d want 1 16", seen, wr_cnt);
      end
   endtask

   task automatic test_reset_mid_job();
      int s, b, bad;
      bit seen;
      clear_mon();
      pulse_start(16, 16, s);
      fork
         send_tiles(4, 32'h30000);
         begin
            b = 0;
            while (wr_cnt < 8 && b < 200) begin
               @(negedge clk); #1;
               b++;
            end
            rst_n = 1'b0;
            abort_send = 1'b1;
            #1;
            n_checks++; if (wr_cnt != 8) begin n_fail++; $display("FAIL mid_beats: got %0d want 8", wr_cnt); end
            n_checks++; if (we !== 1'b0 || addr !== '0 || wdata !== '0) begin
               n_fail++; $display("FAIL mid_sram_zero: got we %b addr %0h wdata %0h want 0", we, addr, wdata);
            end
            n_checks++; if (done !== 1'b0 || err !== 1'b0 || tif.tile_ready_o !== 1'b0) begin
               n_fail++; $display("FAIL mid_ctrl_zero: got done %b err %b ready %b want 0", done, err,
                                  tif.tile_ready_o);
            end
         end
      join
      repeat (4) @(negedge clk);
      n_checks++; if (wr_cnt != 8 || done_cnt != 0) begin
         n_fail++; $display("FAIL mid_quiet: got %0d writes %0d done want 8 0", wr_cnt, done_cnt);
      end
      rst_n = 1'b1;
      clear_mon();
      pulse_start(4, 16, s);
      fork
         send_tiles(1, 32'h40000);
         wait_done(200, seen);
      join
      bad = 0;
      for (int a = 0; a < 16; a++)
         if (c_written[a] !== 1'b1 || c_mem[a] !== expected_word(16, 32'h40000, a)) bad++;
      n_checks++; if (!seen || wr_cnt != 16 || bad != 0) begin
         n_fail++; $display("FAIL post_reset_job: got done %b writes %0d bad %0d want 1 16 0", seen, wr_cnt, bad);
      end
   endtask

   task automatic test_start_ignored();
      int s, b, bad;
      bit seen;
      clear_mon();
      pulse_start(8, 16, s);
      fork
         send_tiles(2, 32'h50000);
         begin
            b = 0;
            while (wr_cnt < 4 && b < 200) begin
               @(negedge clk);
               b++;
            end
            @(posedge clk); #1;
            start = 1'b1; m_size = 32'd4; n_size = 32'd32;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(300, seen);
         end
      join
      repeat (3) @(negedge clk);
      n_checks++; if (seen !== 1'b1 || done_cnt != 1) begin
         n_fail++; $display("FAIL ign_done: got seen %b pulses %0d want 1 1", seen, done_cnt);
      end
      n_checks++; if (wr_cnt != 32) begin n_fail++; $display("FAIL ign_wr_cnt: got %0d want 32", wr_cnt); end
      bad = 0;
      for (int a = 0; a < 32; a++)
         if (c_written[a] !== 1'b1 || c_mem[a] !== expected_word(16, 32'h50000, a)) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ign_data: got %0d bad words want 0", bad); end
   endtask

   initial begin
      tif.tile_valid_i = 1'b0;
      tif.tile_data_i  = '0;
      clear_mon();
      test_reset();
      test_single_tile();
      test_stream();
      test_backpressure();
      test_size_error();
      test_reset_mid_job();
      test_start_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
